tinyqv_qspi_fetch: RTL

- Instruction-side QSPI flash reader directly upstream of the CPU core's instruction fetch port.
- Accepts the core's fetch address, restart and stall controls, and issues quad-I/O fast reads (0xEB) to external flash.
- Returns 16-bit halfwords with a ready pulse and reports fetch started/stopped status.
- Sole owner of the flash CS/SCK/IO pins.

---
 rtl/tinyqv_fetch_pkg.sv | 29 ++
 rtl/tinyqv_spi_shift.sv | 67 ++++++
 rtl/tinyqv_qspi_fetch.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tinyqv_fetch_pkg.sv
// Shared definitions for the QSPI instruction fetch block: FSM state
// encoding, flash command/mode bytes and the length of each bus phase
// counted in SPI clocks.
package tinyqv_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DESELECT,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA
  } fetch_state_t;

  // SPI-clock counts per phase; 4 bits covers the longest phase (8).
  typedef logic [3:0] clk_cnt_t;

  localparam logic [7:0] CMD          = 8'hEB;
  localparam logic [7:0] MODE_BYTE    = 8'hFF;  // 0xFF: no continuous-read
  localparam clk_cnt_t   DUMMY_CYCLES = 4'd4;
  localparam logic [1:0] DESEL_CYCLES = 2'd2;

  localparam clk_cnt_t   CMD_CLKS     = 4'd8;
  localparam clk_cnt_t   ADDR_CLKS    = 4'd6;
  localparam clk_cnt_t   MODE_CLKS    = 4'd2;
  localparam clk_cnt_t   DATA_CLKS    = 4'd4;  // one halfword

endpackage

// File: rtl/tinyqv_spi_shift.sv
// SPI clock generator and nibble shifter for one bus phase.
// A phase is loaded with a length in SPI clocks and the bits to send;
// each SPI clock is one low clk cycle followed by one high clk cycle.
// Outgoing bits advance and incoming nibbles are captured on the edge
// where spi_clk falls.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   abort         drop the current phase immediately (spi_clk -> 0)
//   load          start a new phase (load_clks, load_data, load_quad)
//   hold          keep spi_clk low instead of raising it
//   data_in       sampled IO pins
//   spi_clk       SCK to the flash
//   out_nib       current top nibble of the outgoing shift register
//   in_nibs       last three captured nibbles, oldest in [11:8]
//   last          high in the cycle whose edge ends the phase
module tinyqv_spi_shift
  import tinyqv_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        load,
  input  logic        load_quad,
  input  clk_cnt_t    load_clks,
  input  logic [23:0] load_data,
  input  logic        hold,
  input  logic [3:0]  data_in,
  output logic        spi_clk,
  output logic [3:0]  out_nib,
  output logic [11:0] in_nibs,
  output logic        last
);

  logic [23:0] sr;
  clk_cnt_t    clks_left;
  logic        quad;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      spi_clk   <= 1'b0;
      clks_left <= '0;
      sr        <= '0;
      quad      <= 1'b0;
      in_nibs   <= '0;
    end else if (load) begin
      // Loading coincides with the final falling edge of the previous
      // phase, so spi_clk is low here either way.
      spi_clk   <= 1'b0;
      clks_left <= load_clks;
      sr        <= load_data;
      quad      <= load_quad;
    end else if (clks_left != '0) begin
      if (spi_clk) begin
        spi_clk   <= 1'b0;
        clks_left <= clks_left - 4'd1;
        sr        <= quad ? {sr[19:0], 4'b0} : {sr[22:0], 1'b0};
        in_nibs   <= {in_nibs[7:0], data_in};
      end else if (!hold) begin
        spi_clk <= 1'b1;
      end
    end
  end

  assign out_nib = sr[23:20];
  assign last    = spi_clk && (clks_left == 4'd1);

endmodule

// File: rtl/tinyqv_qspi_fetch.sv
// Instruction-side QSPI flash reader. On restart it deselects the flash,
// then issues a quad-I/O fast read (0xEB) at the latched address and
// streams halfwords to the core until the next restart or reset.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   instr_addr               halfword address; byte address = {addr,0}
//   instr_fetch_restart      abort and start a new read at instr_addr
//   instr_fetch_stall        pause at the next halfword boundary
//   instr_fetch_started      1-cycle pulse as CS falls for a new read
//   instr_fetch_stopped      high while no flash transaction is active
//   instr_data, instr_ready  halfword {byte1, byte0} with 1-cycle strobe
//   spi_cs_n, spi_clk        flash chip select and SCK (mode 0)
//   spi_data_out/oe/in       IO[3:0] drive, enable and sampled values
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_IDLE     | no transaction, waiting for restart
// ST_DESELECT | CS high, counting the minimum deselect time
// ST_CMD      | 0xEB on IO0, WP/HOLD driven high
// ST_ADDR     | 24-bit byte address, one nibble per SPI clock
// ST_MODE     | mode byte 0xFF
// ST_DUMMY    | turnaround, IO released
// ST_DATA     | streaming halfwords, 4 SPI clocks each
module tinyqv_qspi_fetch
  import tinyqv_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] instr_addr,
  input  logic        instr_fetch_restart,
  input  logic        instr_fetch_stall,
  output logic        instr_fetch_started,
  output logic        instr_fetch_stopped,
  output logic [15:0] instr_data,
  output logic        instr_ready,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic [3:0]  spi_data_out,
  output logic [3:0]  spi_data_oe,
  input  logic [3:0]  spi_data_in
);

  fetch_state_t state;
  logic [1:0]   desel_cnt;
  logic [23:0]  addr;
  logic         paused;

  logic         sh_load;
  logic         sh_quad;
  clk_cnt_t     sh_clks;
  logic [23:0]  sh_data;
  logic         sh_hold;
  logic [3:0]   sh_out;
  logic [11:0]  sh_in;
  logic         sh_last;

  // Once paused at a boundary, the first cycle with stall low raises SCK.
  assign sh_hold = paused & instr_fetch_stall;

  tinyqv_spi_shift u_shift (
    .clk       (clk),
    .rst       (rst),
    .abort     (instr_fetch_restart),
    .load      (sh_load),
    .load_quad (sh_quad),
    .load_clks (sh_clks),
    .load_data (sh_data),
    .hold      (sh_hold),
    .data_in   (spi_data_in),
    .spi_clk   (spi_clk),
    .out_nib   (sh_out),
    .in_nibs   (sh_in),
    .last      (sh_last)
  );

  // Next phase is loaded on the edge that ends the current one.
  always_comb begin
    sh_load = 1'b0;
    sh_quad = 1'b1;
    sh_clks = '0;
    sh_data = '0;
    if (!instr_fetch_restart) begin
      case (state)
        ST_DESELECT: if (desel_cnt == 2'd0) begin
          sh_load = 1'b1;
          sh_quad = 1'b0;
          sh_clks = CMD_CLKS;
          sh_data = {CMD, 16'h0};
        end
        ST_CMD: if (sh_last) begin
          sh_load = 1'b1;
          sh_clks = ADDR_CLKS;
          sh_data = addr;
        end
        ST_ADDR: if (sh_last) begin
          sh_load = 1'b1;
          sh_clks = MODE_CLKS;
          sh_data = {MODE_BYTE, 16'h0};
        end
        ST_MODE: if (sh_last) begin
          sh_load = 1'b1;
          sh_clks = DUMMY_CYCLES;
        end
        ST_DUMMY, ST_DATA: if (sh_last) begin
          sh_load = 1'b1;
          sh_clks = DATA_CLKS;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      desel_cnt           <= 2'd0;
      addr                <= '0;
      paused              <= 1'b0;
      spi_cs_n            <= 1'b1;
      spi_data_oe         <= 4'h0;
      instr_data          <= 16'h0;
      instr_ready         <= 1'b0;
      instr_fetch_started <= 1'b0;
      instr_fetch_stopped <= 1'b1;
    end else begin
      instr_ready         <= 1'b0;
      instr_fetch_started <= 1'b0;
      if (instr_fetch_restart) begin
        state               <= ST_DESELECT;
        desel_cnt           <= DESEL_CYCLES;
        addr                <= {instr_addr, 1'b0};
        paused              <= 1'b0;
        spi_cs_n            <= 1'b1;
        spi_data_oe         <= 4'h0;
        instr_fetch_stopped <= 1'b1;
      end else begin
        if (paused && !instr_fetch_stall)
          paused <= 1'b0;
        case (state)
          ST_DESELECT: begin
            if (desel_cnt == 2'd0) begin
              state               <= ST_CMD;
              spi_cs_n            <= 1'b0;
              spi_data_oe         <= 4'b1101;
              instr_fetch_started <= 1'b1;
              instr_fetch_stopped <= 1'b0;
            end else begin
              desel_cnt <= desel_cnt - 2'd1;
            end
          end
          ST_CMD: if (sh_last) begin
            state       <= ST_ADDR;
            spi_data_oe <= 4'hF;
          end
          ST_ADDR: if (sh_last) state <= ST_MODE;
          ST_MODE: if (sh_last) begin
            state       <= ST_DUMMY;
            spi_data_oe <= 4'h0;
          end
          ST_DUMMY: if (sh_last) state <= ST_DATA;
          ST_DATA: if (sh_last) begin
            // Fourth nibble is taken straight from the pins on this edge.
            instr_ready <= 1'b1;
            instr_data  <= {sh_in[3:0], spi_data_in, sh_in[11:8], sh_in[7:4]};
            paused      <= instr_fetch_stall;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    spi_data_out = 4'h0;
    case (state)
      ST_CMD:          spi_data_out = {2'b11, 1'b0, sh_out[3]};
      ST_ADDR, ST_MODE: spi_data_out = sh_out;
      default: ;
    endcase
  end

endmodule
